// File: rtl/lda_weight_seq.sv
`default_nettype none
// lda_weight_seq: computes the LDA projection vector w = Sinv * (m1 - m2) by
// stepping one shared single-precision fpu through an 8-op schedule. Rev 1.0

module lda_fpu #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] y
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Round-to-nearest-even adder; subnormal operands and results flush to zero.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] z);
    logic [31:0] a_big, b_sml;
    logic [7:0]  d;
    logic [26:0] ma, mb, mask;
    logic [27:0] s;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [24:0] m;
    logic        found;
    fadd = 32'h0;
    if (x[30:23] == 8'hFF || z[30:23] == 8'hFF) begin
      if ((x[30:23] == 8'hFF && x[22:0] != '0) || (z[30:23] == 8'hFF && z[22:0] != '0) ||
          (x[30:23] == 8'hFF && z[30:23] == 8'hFF && x[31] != z[31]))
        fadd = QNAN;
      else
        fadd = (x[30:23] == 8'hFF) ? x : z;
    end else if (z[30:23] == '0) begin
      fadd = (x[30:23] == '0) ? 32'h0 : x;
    end else if (x[30:23] == '0) begin
      fadd = z;
    end else begin
      if (x[30:0] >= z[30:0]) begin a_big = x; b_sml = z; end
      else                    begin a_big = z; b_sml = x; end
      d  = a_big[30:23] - b_sml[30:23];
      ma = {1'b1, a_big[22:0], 3'b000};
      mb = {1'b1, b_sml[22:0], 3'b000};
      if (d >= 8'd27) begin
        mb = 27'd1;
      end else begin
        mask = (27'd1 << d) - 27'd1;
        mb   = (mb >> d) | {26'd0, |(mb & mask)};
      end
      s = (a_big[31] == b_sml[31]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
      e = {2'b00, a_big[30:23]};
      if (s != '0) begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 10'd1;
        end else begin
          lz = 5'd0;
          found = 1'b0;
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (s[i]) found = 1'b1;
              else      lz = lz + 5'd1;
            end
          end
          s = s << lz;
          e = e - {5'd0, lz};
        end
        m = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
        if (m[24]) begin
          m = m >> 1;
          e = e + 10'd1;
        end
        if (e[9] || e == '0)     fadd = {a_big[31], 31'd0};
        else if (e >= 10'd255)   fadd = {a_big[31], 8'hFF, 23'd0};
        else                     fadd = {a_big[31], e[7:0], m[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] z);
    logic        sg, g, st;
    logic [47:0] p;
    logic [9:0]  e;
    logic [24:0] m;
    sg   = x[31] ^ z[31];
    fmul = {sg, 31'd0};
    if ((x[30:23] == 8'hFF && x[22:0] != '0) || (z[30:23] == 8'hFF && z[22:0] != '0)) begin
      fmul = QNAN;
    end else if (x[30:23] == 8'hFF || z[30:23] == 8'hFF) begin
      fmul = (x[30:23] == '0 || z[30:23] == '0) ? QNAN : {sg, 8'hFF, 23'd0};
    end else if (x[30:23] != '0 && z[30:23] != '0) begin
      p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, z[22:0]};
      e = {2'b00, x[30:23]} + {2'b00, z[30:23]} - 10'd127;
      if (p[47]) begin
        m  = {1'b0, p[47:24]};
        g  = p[23];
        st = |p[22:0];
        e  = e + 10'd1;
      end else begin
        m  = {1'b0, p[46:23]};
        g  = p[22];
        st = |p[21:0];
      end
      m = m + {24'd0, g & (st | m[0])};
      if (m[24]) begin
        m = m >> 1;
        e = e + 10'd1;
      end
      if (e[9] || e == '0)     fmul = {sg, 31'd0};
      else if (e >= 10'd255)   fmul = {sg, 8'hFF, 23'd0};
      else                     fmul = {sg, e[7:0], m[22:0]};
    end
  endfunction

  logic [31:0] res;
  logic [31:0] pipe [LAT];

  always_comb begin
    res = 32'h0;
    case (op)
      2'b00:   res = fadd(a, b);
      2'b01:   res = fadd(a, {~b[31], b[30:0]});
      2'b11:   res = fmul(a, b);
      default: res = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 32'h0;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[LAT-1];
endmodule

module lda_weight_seq #(
  parameter int FPU_LAT = 6,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  input  logic [W-1:0] s3,
  input  logic [W-1:0] s4,
  input  logic [W-1:0] m1x,
  input  logic [W-1:0] m1y,
  input  logic [W-1:0] m2x,
  input  logic [W-1:0] m2y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] w1,
  output logic [W-1:0] w2,
  output logic         out_err
);
  localparam int            CW       = $clog2(FPU_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FPU_LAT - 1);
  localparam logic [1:0]    OP_ADD   = 2'b00;
  localparam logic [1:0]    OP_SUB   = 2'b01;
  localparam logic [1:0]    OP_MUL   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [2:0]    k;
  logic [CW-1:0] cnt;
  logic [W-1:0]  reg_s1, reg_s2, reg_s3, reg_s4;
  logic [W-1:0]  reg_m1x, reg_m1y, reg_m2x, reg_m2y;
  logic [W-1:0]  d1, d2, p1, p2, p3, p4;
  logic [W-1:0]  fpu_a, fpu_b, fpu_y;
  logic [1:0]    fpu_op;

  // Operands depend only on k, so they stay put from ISSUE until capture.
  always_comb begin
    fpu_a  = '0;
    fpu_b  = '0;
    fpu_op = OP_ADD;
    case (k)
      3'd0: begin fpu_a = reg_m1x; fpu_b = reg_m2x; fpu_op = OP_SUB; end
      3'd1: begin fpu_a = reg_m1y; fpu_b = reg_m2y; fpu_op = OP_SUB; end
      3'd2: begin fpu_a = reg_s1;  fpu_b = d1;      fpu_op = OP_MUL; end
      3'd3: begin fpu_a = reg_s2;  fpu_b = d2;      fpu_op = OP_MUL; end
      3'd4: begin fpu_a = reg_s3;  fpu_b = d1;      fpu_op = OP_MUL; end
      3'd5: begin fpu_a = reg_s4;  fpu_b = d2;      fpu_op = OP_MUL; end
      3'd6: begin fpu_a = p1;      fpu_b = p2;      fpu_op = OP_ADD; end
      3'd7: begin fpu_a = p3;      fpu_b = p4;      fpu_op = OP_ADD; end
    endcase
  end

  lda_fpu #(.LAT(FPU_LAT)) u_fpu (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (fpu_a),
    .b     (fpu_b),
    .op    (fpu_op),
    .y     (fpu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      k         <= 3'd0;
      cnt       <= '0;
      reg_s1  <= '0; reg_s2  <= '0; reg_s3  <= '0; reg_s4  <= '0;
      reg_m1x <= '0; reg_m1y <= '0; reg_m2x <= '0; reg_m2y <= '0;
      d1 <= '0; d2 <= '0; p1 <= '0; p2 <= '0; p3 <= '0; p4 <= '0;
      w1 <= '0; w2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            reg_s1  <= s1;  reg_s2  <= s2;  reg_s3  <= s3;  reg_s4  <= s4;
            reg_m1x <= m1x; reg_m1y <= m1y; reg_m2x <= m2x; reg_m2y <= m2y;
            k        <= 3'd0;
            out_err  <= 1'b0;
            in_ready <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            case (k)
              3'd0: d1 <= fpu_y;
              3'd1: d2 <= fpu_y;
              3'd2: p1 <= fpu_y;
              3'd3: p2 <= fpu_y;
              3'd4: p3 <= fpu_y;
              3'd5: p4 <= fpu_y;
              3'd6: w1 <= fpu_y;
              3'd7: w2 <= fpu_y;
            endcase
            if (fpu_y[30:23] == 8'hFF) out_err <= 1'b1;
            if (k == 3'd7) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              k     <= k + 3'd1;
              state <= ISSUE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lda_weight_seq.sv
`default_nettype none
// tb_lda_weight_seq: scoreboard bench for lda_weight_seq covering latency,
// backpressure, NaN flagging, mid-run reset and back-to-back runs.
module tb_lda_weight_seq;
  localparam int LAT     = 6;
  localparam int LATENCY = 8 * (LAT + 1) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] s1 = '0, s2 = '0, s3 = '0, s4 = '0;
  logic [31:0] m1x = '0, m1y = '0, m2x = '0, m2y = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] w1, w2;
  logic        out_err;

  typedef struct packed {
    logic [31:0] w1;
    logic [31:0] w2;
    logic        err;
    logic        chk_w1;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_tab [3];
  exp_t        mon_e;
  logic [31:0] vec [3][8];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          xfer_edge = 0;
  int          last_rise = -1;
  bit          check_gap = 1'b0;
  logic        ov_q = 1'b0;
  logic [31:0] hold_w1, hold_w2;

  lda_weight_seq #(.FPU_LAT(LAT), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .s4        (s4),
    .m1x       (m1x),
    .m1y       (m1y),
    .m2x       (m2x),
    .m2y       (m2y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w1        (w1),
    .w2        (w2),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Latency, spacing and scoreboard pops, all sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && !ov_q) begin
      chk("latency", 32'(cyc - xfer_edge + 1), 32'(LATENCY));
      if (check_gap && last_rise >= 0) chk("spacing", 32'(cyc - last_rise), 32'(LATENCY + 1));
      last_rise = cyc;
    end
    ov_q = out_valid;
    if (rst_n && in_valid && in_ready) xfer_edge = cyc + 1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_w1) chk("w1", w1, mon_e.w1);
        chk("w2", w2, mon_e.w2);
        chk("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  task automatic drive_ops(input int idx);
    s1  = vec[idx][0]; s2  = vec[idx][1]; s3  = vec[idx][2]; s4  = vec[idx][3];
    m1x = vec[idx][4]; m1y = vec[idx][5]; m2x = vec[idx][6]; m2y = vec[idx][7];
  endtask

  task automatic send(input int idx, input bit hold);
    int n;
    drive_ops(idx);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back(exp_tab[idx]);
      @(posedge clk); #1;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vec[0] = '{32'h3F800000, 32'h0, 32'h0, 32'h3F800000,
               32'h40400000, 32'h40A00000, 32'h3F800000, 32'h3F800000};
    vec[1] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000,
               32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vec[2] = vec[0];
    vec[2][0] = 32'h7FC00000;
    exp_tab[0] = '{w1: 32'h40000000, w2: 32'h40800000, err: 1'b0, chk_w1: 1'b1};
    exp_tab[1] = '{w1: 32'h3F800000, w2: 32'hBF800000, err: 1'b0, chk_w1: 1'b1};
    exp_tab[2] = '{w1: 32'h0,        w2: 32'h40800000, err: 1'b1, chk_w1: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_w1", w1, 32'h0);
    chk("rst_w2", w2, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 1'b0); wait_drain();
    send(1, 1'b0); wait_drain();

    // Backpressure: result must hold while the new request is refused.
    out_ready = 1'b0;
    send(0, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    hold_w1 = 32'h40000000;
    hold_w2 = 32'h40800000;
    drive_ops(1);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_w1", w1, hold_w1);
      chk("bp_w2", w2, hold_w2);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    send(2, 1'b0); wait_drain();
    send(0, 1'b0); wait_drain();

    // Mid-run reset, then a clean run must come out at full latency.
    send(0, 1'b0);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    chk("mrst_w1", w1, 32'h0);
    chk("mrst_w2", w2, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1, 1'b0); wait_drain();

    last_rise = -1;
    check_gap = 1'b1;
    send(0, 1'b1);
    send(1, 1'b1);
    send(0, 1'b1);
    send(1, 1'b0);
    wait_drain();
    check_gap = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
